// File: rtl/sr04_echo_emulator_if.sv
// sr04_echo_emulator_if: trig/echo link between reader and emulator.
// Carries trigger, sensor select, distances and echo status.
interface sr04_echo_emulator_if;
  logic        trig_tx;
  logic [3:0]  mux_sensor_select;
  logic [63:0] distance_cm_flat;
  logic        echo_rx;
  logic        busy;
  logic        trig_err;
  logic [15:0] echo_count;

  modport master (
    output trig_tx,
    output mux_sensor_select,
    output distance_cm_flat,
    input  echo_rx,
    input  busy,
    input  trig_err,
    input  echo_count
  );

  modport slave (
    input  trig_tx,
    input  mux_sensor_select,
    input  distance_cm_flat,
    output echo_rx,
    output busy,
    output trig_err,
    output echo_count
  );
endinterface

// File: rtl/sr04_echo_emulator.sv
// sr04_echo_emulator: responder side of the HC-SR04 trig/echo protocol.
// Echo width follows the latched distance of the selected sensor.
module sr04_echo_emulator #(
  parameter int unsigned MIN_TRIG_US   = 10,
  parameter int unsigned RESP_DELAY_US = 200,
  parameter int unsigned US_PER_CM     = 58,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 1000
) (
  input logic clk,
  input logic reset,
  input logic clock_1MHz,
  input logic clock_1MHz_prev,
  sr04_echo_emulator_if.slave bus
);

  localparam logic [23:0] MIN_W  = 24'(MIN_TRIG_US);
  localparam logic [23:0] DLY_W  = 24'(RESP_DELAY_US);
  localparam logic [23:0] UPC_W  = 24'(US_PER_CM);
  localparam logic [23:0] TMO_W  = 24'(TIMEOUT_US);
  localparam logic [23:0] HOLD_W = 24'(HOLDOFF_US);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    DELAY,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  trig_sync;
  logic        tick;
  logic        trig_rise;
  logic        trig_fall;
  logic [23:0] us_cnt;
  logic [23:0] cnt_inc;
  logic [23:0] width;
  logic [23:0] width_n;
  logic [23:0] sel_width;
  logic [7:0]  sel_dist;
  logic        echo_q;
  logic        err_q;
  logic        err_n;
  logic        done;
  logic [15:0] cnt_q;

  assign tick      = clock_1MHz & ~clock_1MHz_prev;
  assign trig_rise = trig_sync[1] & ~trig_sync[2];
  assign trig_fall = ~trig_sync[1] & trig_sync[2];

  // Saturating: a trig held high forever must not wrap into a short pulse.
  assign cnt_inc = (tick && us_cnt != '1) ? us_cnt + 24'd1 : us_cnt;

  assign sel_dist = bus.distance_cm_flat[
    {bus.mux_sensor_select[2:0], 3'b000} +: 8];

  assign sel_width =
    (bus.mux_sensor_select[3] || sel_dist == 8'd0) ? TMO_W :
    24'(sel_dist) * UPC_W;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trig_sync <= '0;
    end else begin
      trig_sync <= {trig_sync[1:0], bus.trig_tx};
    end
  end

  // Next-state decode; the tick on a falling-edge clk is already in cnt_inc.
  always_comb begin
    state_n = state;
    width_n = width;
    err_n   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig_rise) state_n = TRIG_HIGH;
      end
      TRIG_HIGH: begin
        if (trig_fall) begin
          if (cnt_inc >= MIN_W) begin
            width_n = sel_width;
            state_n = DELAY;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      DELAY: begin
        if (tick && cnt_inc >= DLY_W) state_n = ECHO;
      end
      ECHO: begin
        if (tick && cnt_inc >= width) begin
          done    = 1'b1;
          state_n = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (tick && cnt_inc >= HOLD_W) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, phase counter and registered outputs; counter restarts per state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      us_cnt <= '0;
      width  <= '0;
      echo_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      us_cnt <= (state_n != state) ? '0 : cnt_inc;
      width  <= width_n;
      echo_q <= (state_n == ECHO);
      err_q  <= err_n;
      if (done) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.echo_rx    = echo_q;
  assign bus.busy       = (state != IDLE);
  assign bus.trig_err   = err_q;
  assign bus.echo_count = cnt_q;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// tb_sr04_echo_emulator: scenario bench for the echo emulator.
// A tick is presented every clk, so one clk equals one us.
module tb_sr04_echo_emulator;

  localparam int DLY  = 200;
  localparam int UPC  = 58;
  localparam int TMO  = 38000;
  localparam int HOLD = 1000;
  // raw trig fall -> 2 sync flops -> edge acted on one clk later
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic c1m = 1'b1;
  logic c1m_prev = 1'b0;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  sr04_echo_emulator_if bus ();

  sr04_echo_emulator dut (
    .clk(clk),
    .reset(reset),
    .clock_1MHz(c1m),
    .clock_1MHz_prev(c1m_prev),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic set_dist(input int i, input logic [7:0] d);
    bus.distance_cm_flat[8*i +: 8] = d;
  endtask

  task automatic pulse_trig(input int n);
    @(negedge clk);
    bus.trig_tx = 1'b1;
    repeat (n) @(negedge clk);
    bus.trig_tx = 1'b0;
  endtask

  // Call right after trig falls: clks to echo, echo width, busy tail.
  task automatic measure(output int dly, output int wid,
                         output int hold, output bit ok);
    dly = 0;
    wid = 0;
    hold = 0;
    while (!bus.echo_rx && dly < 50000) begin
      @(negedge clk);
      dly++;
    end
    while (bus.echo_rx && wid < 50000) begin
      @(negedge clk);
      wid++;
    end
    while (bus.busy && hold < 5000) begin
      @(negedge clk);
      hold++;
    end
    ok = (wid > 0) && !bus.echo_rx && !bus.busy;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.trig_tx = ~bus.trig_tx;
      checks++;
      if ({bus.echo_rx, bus.busy, bus.echo_count} !== 18'd0) begin
        errors++;
        $display("FAIL reset_hold: echo=%b busy=%b cnt=%0d need 0/0/0",
                 bus.echo_rx, bus.busy, bus.echo_count);
      end
    end
    @(negedge clk);
    bus.trig_tx = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({bus.echo_rx, bus.busy, bus.trig_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: echo=%b busy=%b err=%b need 000",
               bus.echo_rx, bus.busy, bus.trig_err);
    end
  endtask

  task automatic test_nominal;
    int d, w, h, e, c0;
    bit ok;
    bus.mux_sensor_select = 4'd3;
    set_dist(3, 8'd25);
    c0 = int'(bus.echo_count);
    exp_q.push_back(25 * UPC);
    pulse_trig(12);
    measure(d, w, h, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || w != e) begin
      errors++;
      $display("FAIL nominal_width: got %0d need %0d ok=%0b", w, e, ok);
    end
    checks++;
    if (d != DLY + LAT) begin
      errors++;
      $display("FAIL nominal_delay: got %0d need %0d", d, DLY + LAT);
    end
    checks++;
    if (h != HOLD) begin
      errors++;
      $display("FAIL nominal_holdoff: got %0d need %0d", h, HOLD);
    end
    checks++;
    if (int'(bus.echo_count) != c0 + 1) begin
      errors++;
      $display("FAIL nominal_count: got %0d need %0d",
               bus.echo_count, c0 + 1);
    end
  endtask

  task automatic test_short_trig(input int n);
    int errs, echoes, c0;
    errs = 0;
    echoes = 0;
    c0 = int'(bus.echo_count);
    pulse_trig(n);
    repeat (20) begin
      @(negedge clk);
      if (bus.trig_err) errs++;
      if (bus.echo_rx) echoes++;
    end
    checks++;
    if (errs != 1) begin
      errors++;
      $display("FAIL short_err_%0d: pulses %0d need 1", n, errs);
    end
    checks++;
    if (echoes != 0 || bus.busy !== 1'b0 ||
        int'(bus.echo_count) != c0) begin
      errors++;
      $display("FAIL short_quiet_%0d: echo=%0d busy=%b cnt=%0d need 0/0/%0d",
               n, echoes, bus.busy, bus.echo_count, c0);
    end
  endtask

  task automatic test_no_object;
    int d, w, h, e;
    bit ok;
    bus.mux_sensor_select = 4'd0;
    set_dist(0, 8'd0);
    exp_q.push_back(TMO);
    pulse_trig(12);
    measure(d, w, h, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || w != e) begin
      errors++;
      $display("FAIL noobj_zero: got %0d need %0d", w, e);
    end
    bus.mux_sensor_select = 4'd9;
    set_dist(1, 8'd50);
    exp_q.push_back(TMO);
    pulse_trig(12);
    measure(d, w, h, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || w != e) begin
      errors++;
      $display("FAIL noobj_sel9: got %0d need %0d", w, e);
    end
  endtask

  task automatic test_back_to_back;
    int d, w, h, e, c0, extra;
    bit ok;
    bus.mux_sensor_select = 4'd3;
    set_dist(3, 8'd25);
    c0 = int'(bus.echo_count);
    exp_q.push_back(25 * UPC);
    pulse_trig(12);
    fork
      measure(d, w, h, ok);
      begin
        repeat (300) @(negedge clk);
        set_dist(3, 8'd200);
        pulse_trig(12);
      end
    join
    e = exp_q.pop_front();
    checks++;
    if (!ok || w != e) begin
      errors++;
      $display("FAIL retrig_width: got %0d need %0d", w, e);
    end
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.echo_rx || bus.busy) extra++;
    end
    checks++;
    if (extra != 0 || int'(bus.echo_count) != c0 + 1) begin
      errors++;
      $display("FAIL retrig_single: extra=%0d cnt=%0d need 0/%0d",
               extra, bus.echo_count, c0 + 1);
    end
    set_dist(3, 8'd25);
  endtask

  task automatic test_reset_mid_and_wrap;
    int d, w, h, e, wait_n;
    bit ok;
    bus.mux_sensor_select = 4'd3;
    set_dist(3, 8'd25);
    pulse_trig(12);
    wait_n = 0;
    while (!bus.echo_rx && wait_n < 1000) begin
      @(negedge clk);
      wait_n++;
    end
    repeat (700) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.echo_rx, bus.busy, bus.echo_count} !== 18'd0 ||
        wait_n >= 1000) begin
      errors++;
      $display("FAIL reset_mid: echo=%b busy=%b cnt=%0d need 0/0/0",
               bus.echo_rx, bus.busy, bus.echo_count);
    end
    reset = 1'b1;
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    @(negedge clk);
    checks++;
    if (bus.echo_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL preload: got %h need ffff", bus.echo_count);
    end
    exp_q.push_back(25 * UPC);
    pulse_trig(10);
    measure(d, w, h, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || w != e || d != DLY + LAT) begin
      errors++;
      $display("FAIL post_reset_echo: w=%0d d=%0d need %0d/%0d",
               w, d, e, DLY + LAT);
    end
    checks++;
    if (bus.echo_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_wrap: got %h need 0000", bus.echo_count);
    end
  endtask

  initial begin
    bus.trig_tx = 1'b0;
    bus.mux_sensor_select = 4'd0;
    bus.distance_cm_flat = '0;
    test_reset;
    test_nominal;
    test_short_trig(6);
    test_short_trig(9);
    test_no_object;
    test_back_to_back;
    test_reset_mid_and_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
